// File: rtl/dcache_coh_ctrl_pkg.sv
// Shared types and constants for the coherent data-cache controller:
// line coherence states, controller FSM states and bus encodings.
package dcache_coh_ctrl_pkg;
    localparam int NUM_LINES = 4;
    localparam int IDX_W     = 2;
    localparam int TAG_W     = 3;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 16;

    typedef enum logic [1:0] {
        INV = 2'b00,
        SHR = 2'b01,
        MOD = 2'b10
    } coh_state_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        MISS_REQ,
        MISS_WAIT,
        FILL
    } ctrl_state_t;

    localparam logic [1:0] WMS_INV    = 2'b01;
    localparam logic [1:0] WMS_SHARED = 2'b10;
endpackage

// File: rtl/dcache_coh_ctrl_if.sv
// Bus-side signals of the cache controller: miss requests, grant, fill,
// victim writeback and snoop lookup. master = controller, slave = bus.
interface dcache_coh_ctrl_if;
    import dcache_coh_ctrl_pkg::*;

    logic                read_miss;
    logic                write_miss;
    logic [1:0]          write_miss_state;
    logic [ADDR_W-1:0]   tag_in;
    logic                bus_grant;
    logic                bus_owner;
    logic                fill_valid;
    logic [DATA_W-1:0]   fill_data;
    logic                wb_req;
    logic                wb_ack;
    logic [DATA_W-1:0]   wb_data;
    logic                snoop_search;
    logic                snoop_inv;
    logic [ADDR_W-1:0]   snoop_tag;
    logic                search_found;
    logic [DATA_W-1:0]   snoop_data;

    modport master (
        output read_miss, write_miss, write_miss_state, tag_in, wb_req, wb_data,
               search_found, snoop_data,
        input  bus_grant, bus_owner, fill_valid, fill_data, wb_ack,
               snoop_search, snoop_inv, snoop_tag
    );

    modport slave (
        input  read_miss, write_miss, write_miss_state, tag_in, wb_req, wb_data,
               search_found, snoop_data,
        output bus_grant, bus_owner, fill_valid, fill_data, wb_ack,
               snoop_search, snoop_inv, snoop_tag
    );
endinterface

// File: rtl/dcache_line_array.sv
// Four-entry direct-mapped line store with a combinational local read/write
// port and a snoop port that can downgrade (M->S) or invalidate a line.
module dcache_line_array
    import dcache_coh_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_idx,
    output coh_state_t        o_state,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_we,
    input  coh_state_t        i_wstate,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_snp_search,
    input  logic              i_snp_inv,
    input  logic [ADDR_W-1:0] i_snp_addr,
    output logic              o_snp_hit,
    output logic [DATA_W-1:0] o_snp_data
);
    coh_state_t        r_state [NUM_LINES];
    logic [TAG_W-1:0]  r_tag   [NUM_LINES];
    logic [DATA_W-1:0] r_data  [NUM_LINES];

    logic [IDX_W-1:0]     w_snp_idx;
    logic [NUM_LINES-1:0] w_wr_sel, w_inv_sel, w_dgr_sel;

    assign o_state    = r_state[i_idx];
    assign o_tag      = r_tag[i_idx];
    assign o_data     = r_data[i_idx];
    assign w_snp_idx  = i_snp_addr[IDX_W-1:0];
    assign o_snp_hit  = (r_state[w_snp_idx] != INV) &&
                        (r_tag[w_snp_idx] == i_snp_addr[ADDR_W-1:IDX_W]);
    assign o_snp_data = r_data[w_snp_idx];

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_sel
            assign w_wr_sel[gi]  = i_we && (i_idx == IDX_W'(gi));
            assign w_inv_sel[gi] = i_snp_inv && o_snp_hit && (w_snp_idx == IDX_W'(gi));
            assign w_dgr_sel[gi] = i_snp_search && o_snp_hit && (w_snp_idx == IDX_W'(gi)) &&
                                   (r_state[gi] == MOD);
        end
    endgenerate

    // The controller withholds conflicting local writes, so a local write here always wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LINES; i++) begin
            if (rst) begin
                r_state[i] <= INV;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end else if (w_wr_sel[i]) begin
                r_state[i] <= i_wstate;
                r_tag[i]   <= i_wtag;
                r_data[i]  <= i_wdata;
            end else if (w_inv_sel[i]) begin
                r_state[i] <= INV;
            end else if (w_dgr_sel[i]) begin
                r_state[i] <= SHR;
            end
        end
    end
endmodule

// File: rtl/dcache_coh_ctrl.sv
// MSI data-cache controller for one core: hit service, victim writeback,
// bus miss/upgrade requests, line fill and snoop response.
module dcache_coh_ctrl
    import dcache_coh_ctrl_pkg::*;
#(
    parameter bit CORE_ID = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    dcache_coh_ctrl_if.master bus
);
    ctrl_state_t       r_state, w_state_next;
    logic [DATA_W-1:0] r_fill_data;

    coh_state_t        w_line_state, w_arr_state;
    logic [TAG_W-1:0]  w_line_tag, w_arr_tag, w_tag;
    logic [DATA_W-1:0] w_line_data, w_arr_data, w_snp_data;
    logic [IDX_W-1:0]  w_idx;
    logic              w_arr_we, w_snp_hit, w_snp_same, w_tag_hit, w_wr_conflict, w_upgrade;

    assign w_idx      = cpu_addr[IDX_W-1:0];
    assign w_tag      = cpu_addr[ADDR_W-1:IDX_W];
    assign w_tag_hit  = (w_line_state != INV) && (w_line_tag == w_tag);
    assign w_snp_same = w_snp_hit && (bus.snoop_tag[IDX_W-1:0] == w_idx);
    // A snoop touching the line we want to write takes precedence; the store waits.
    assign w_wr_conflict = w_tag_hit && w_snp_same &&
                           (bus.snoop_inv || (bus.snoop_search && w_line_state == MOD));
    assign w_upgrade  = w_tag_hit && (w_line_state == SHR) && !(bus.snoop_inv && w_snp_same);

    dcache_line_array u_lines (
        .clk          (clk),
        .rst          (rst),
        .i_idx        (w_idx),
        .o_state      (w_line_state),
        .o_tag        (w_line_tag),
        .o_data       (w_line_data),
        .i_we         (w_arr_we),
        .i_wstate     (w_arr_state),
        .i_wtag       (w_arr_tag),
        .i_wdata      (w_arr_data),
        .i_snp_search (bus.snoop_search),
        .i_snp_inv    (bus.snoop_inv),
        .i_snp_addr   (bus.snoop_tag),
        .o_snp_hit    (w_snp_hit),
        .o_snp_data   (w_snp_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fill_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == MISS_WAIT && bus.fill_valid) begin
                r_fill_data <= bus.fill_data;
            end
        end
    end

    always_comb begin
        w_state_next         = r_state;
        stall                = 1'b0;
        cpu_rdata            = '0;
        bus.read_miss        = 1'b0;
        bus.write_miss       = 1'b0;
        bus.write_miss_state = 2'b00;
        bus.tag_in           = '0;
        bus.wb_req           = 1'b0;
        bus.wb_data          = '0;
        bus.search_found     = bus.snoop_search && w_snp_hit;
        bus.snoop_data       = bus.search_found ? w_snp_data : '0;
        w_arr_we             = 1'b0;
        w_arr_state          = INV;
        w_arr_tag            = w_line_tag;
        w_arr_data           = w_line_data;

        case (r_state)
            IDLE: begin
                if (cpu_rd && w_tag_hit) begin
                    cpu_rdata = w_line_data;
                end else if (cpu_wr && w_tag_hit && w_line_state == MOD && !w_wr_conflict) begin
                    w_arr_we    = 1'b1;
                    w_arr_state = MOD;
                    w_arr_data  = cpu_wdata;
                end else if (cpu_rd || cpu_wr) begin
                    stall = 1'b1;
                    if (!(cpu_wr && w_wr_conflict)) begin
                        w_state_next = (!w_tag_hit && w_line_state == MOD) ? WB : MISS_REQ;
                    end
                end
            end
            WB: begin
                stall       = 1'b1;
                bus.wb_req  = 1'b1;
                bus.tag_in  = {w_line_tag, w_idx};
                bus.wb_data = w_line_data;
                if (bus.wb_ack) begin
                    w_arr_we     = 1'b1;
                    w_arr_state  = INV;
                    w_state_next = MISS_REQ;
                end
            end
            MISS_REQ: begin
                stall      = 1'b1;
                bus.tag_in = cpu_addr;
                if (cpu_wr) begin
                    bus.write_miss       = 1'b1;
                    bus.write_miss_state = w_upgrade ? WMS_SHARED : WMS_INV;
                end else begin
                    bus.read_miss = 1'b1;
                end
                if (bus.bus_grant && bus.bus_owner == CORE_ID) begin
                    w_state_next = (cpu_wr && w_upgrade) ? FILL : MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                stall = 1'b1;
                if (bus.fill_valid) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                w_arr_we     = 1'b1;
                w_arr_tag    = w_tag;
                w_state_next = IDLE;
                if (cpu_wr) begin
                    w_arr_state = MOD;
                    w_arr_data  = cpu_wdata;
                end else begin
                    w_arr_state = SHR;
                    w_arr_data  = r_fill_data;
                    cpu_rdata   = r_fill_data;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Outputs read as idle while reset is held.
        if (rst) begin
            stall                = 1'b0;
            cpu_rdata            = '0;
            bus.read_miss        = 1'b0;
            bus.write_miss       = 1'b0;
            bus.write_miss_state = 2'b00;
            bus.tag_in           = '0;
            bus.wb_req           = 1'b0;
            bus.wb_data          = '0;
            bus.search_found     = 1'b0;
            bus.snoop_data       = '0;
        end
    end
endmodule

// File: tb/tb_dcache_coh_ctrl.sv
// Self-checking bench: directed scenarios plus random loads/stores/snoops,
// checked against a per-line MSI table and a backing memory image.
module tb_dcache_coh_ctrl;
    localparam bit CORE = 1'b0;
    localparam logic [1:0] I_ = 2'd0, S_ = 2'd1, M_ = 2'd2;

    logic        clk, rst, cpu_rd, cpu_wr, stall;
    logic [4:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;

    dcache_coh_ctrl_if bus_if ();

    dcache_coh_ctrl #(.CORE_ID(CORE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: line table and memory image returned on fills.
    logic [1:0]  m_state [4];
    logic [2:0]  m_tag   [4];
    logic [15:0] m_data  [4];
    logic [15:0] mem     [32];
    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_state[i] = I_;
    endtask

    task automatic do_access(input bit is_wr, input logic [4:0] addr, input logic [15:0] wd);
        logic [1:0] idx;
        logic [2:0] tg;
        bit hit, upg;
        int n;
        idx = addr[1:0];
        tg  = addr[4:2];
        hit = (m_state[idx] != I_) && (m_tag[idx] == tg);
        cpu_rd = !is_wr; cpu_wr = is_wr; cpu_addr = addr; cpu_wdata = wd;
        #1;
        if (hit && (!is_wr || m_state[idx] == M_)) begin
            check("hit_stall", stall, 0);
            if (!is_wr) check("hit_rdata", cpu_rdata, m_data[idx]);
            tick();
            if (is_wr) m_data[idx] = wd;
        end else begin
            upg = is_wr && hit;
            check("req_stall", stall, 1);
            tick();
            if (!hit && m_state[idx] == M_) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k <= n; k++) begin
                    bus_if.wb_ack = (k == n);
                    #1;
                    check("wb_req", bus_if.wb_req, 1);
                    check("wb_tag", bus_if.tag_in, {m_tag[idx], idx});
                    check("wb_data", bus_if.wb_data, m_data[idx]);
                    check("wb_stall", stall, 1);
                    tick();
                end
                bus_if.wb_ack = 1'b0;
                mem[{m_tag[idx], idx}] = m_data[idx];
                m_state[idx] = I_;
            end
            n = $urandom_range(0, 3);
            for (int k = 0; k <= n; k++) begin
                if (k == n) begin
                    bus_if.bus_grant = 1'b1; bus_if.bus_owner = CORE;
                end else begin
                    bus_if.bus_grant = 1'($urandom_range(0, 1)); bus_if.bus_owner = ~CORE;
                end
                #1;
                check("read_miss", bus_if.read_miss, !is_wr);
                check("write_miss", bus_if.write_miss, is_wr);
                check("wms", bus_if.write_miss_state, is_wr ? (upg ? 2 : 1) : 0);
                check("miss_tag", bus_if.tag_in, addr);
                check("miss_stall", stall, 1);
                tick();
            end
            bus_if.bus_grant = 1'b0; bus_if.bus_owner = 1'b0;
            if (!upg) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k <= n; k++) begin
                    bus_if.fill_valid = (k == n);
                    bus_if.fill_data  = (k == n) ? mem[addr] : 16'($urandom);
                    #1;
                    check("wait_stall", stall, 1);
                    check("wait_rmiss", bus_if.read_miss, 0);
                    tick();
                end
                bus_if.fill_valid = 1'b0;
            end
            #1;
            check("fill_stall", stall, 0);
            if (!is_wr) check("fill_rdata", cpu_rdata, mem[addr]);
            tick();
            m_tag[idx]   = tg;
            m_state[idx] = is_wr ? M_ : S_;
            m_data[idx]  = is_wr ? wd : mem[addr];
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic do_snoop(input bit inv, input logic [4:0] a);
        logic [1:0] idx;
        bit found;
        idx   = a[1:0];
        found = (m_state[idx] != I_) && (m_tag[idx] == a[4:2]);
        bus_if.snoop_search = !inv; bus_if.snoop_inv = inv; bus_if.snoop_tag = a;
        #1;
        check("search_found", bus_if.search_found, inv ? 0 : found);
        if (!inv) check("snoop_data", bus_if.snoop_data, found ? m_data[idx] : 16'h0);
        tick();
        bus_if.snoop_search = 1'b0; bus_if.snoop_inv = 1'b0;
        if (found) m_state[idx] = inv ? I_ : S_;
    endtask

    initial begin
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus_if.bus_grant = 1'b0; bus_if.bus_owner = 1'b0; bus_if.fill_valid = 1'b0;
        bus_if.fill_data = '0; bus_if.wb_ack = 1'b0; bus_if.snoop_search = 1'b0;
        bus_if.snoop_inv = 1'b0; bus_if.snoop_tag = '0;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[5'h06] = 16'hBEEF;
        model_reset();
        tick(); tick();
        check("rst_stall", stall, 0);
        check("rst_rmiss", bus_if.read_miss, 0);
        check("rst_wmiss", bus_if.write_miss, 0);
        check("rst_wms", bus_if.write_miss_state, 0);
        check("rst_wbreq", bus_if.wb_req, 0);
        check("rst_tagin", bus_if.tag_in, 0);
        check("rst_wbdata", bus_if.wb_data, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_found", bus_if.search_found, 0);
        check("rst_sdata", bus_if.snoop_data, 0);
        rst = 1'b0;
        tick();

        // Cold load, S upgrade, dirty eviction, snoop downgrade.
        do_access(1'b0, 5'h06, 16'h0);
        do_snoop(1'b0, 5'h06);
        do_access(1'b1, 5'h06, 16'h1234);
        do_access(1'b0, 5'h0A, 16'h0);
        do_access(1'b1, 5'h06, 16'h1234);
        do_snoop(1'b0, 5'h06);
        do_access(1'b1, 5'h06, 16'h4321);
        do_snoop(1'b0, 5'h06);

        // Store racing a snoop invalidate on the same S line.
        cpu_wr = 1'b1; cpu_addr = 5'h06; cpu_wdata = 16'h5678;
        bus_if.snoop_inv = 1'b1; bus_if.snoop_tag = 5'h06;
        #1;
        check("conflict_stall", stall, 1);
        tick();
        bus_if.snoop_inv = 1'b0;
        m_state[2] = I_;
        do_access(1'b1, 5'h06, 16'h5678);

        // Reset while waiting for fill data.
        cpu_rd = 1'b1; cpu_addr = 5'h1B;
        #1;
        check("pre_rst_stall", stall, 1);
        tick();
        bus_if.bus_grant = 1'b1; bus_if.bus_owner = CORE;
        tick();
        bus_if.bus_grant = 1'b0;
        #1;
        check("mw_stall", stall, 1);
        rst = 1'b1; cpu_rd = 1'b0;
        tick();
        check("rst_mw_stall", stall, 0);
        check("rst_mw_rmiss", bus_if.read_miss, 0);
        rst = 1'b0;
        model_reset();
        tick();
        do_snoop(1'b0, 5'h06);
        do_access(1'b0, 5'h1B, 16'h0);

        for (int it = 0; it < 80; it++) begin
            logic [4:0] a;
            int op;
            a  = {3'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 9);
            if (op < 4)       do_access(1'b0, a, 16'h0);
            else if (op < 8)  do_access(1'b1, a, 16'($urandom));
            else              do_snoop(op == 9, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
